// File: rtl/board_store.sv
// board_store: Avalon-MM responder serving chess boards from local RAM with a fixed-latency, in-order read pipe.
// Optional macro BOARD_STORE_START_POS_EN: the clear sweep loads board 0 with the standard start position.
module board_store #(
    parameter int unsigned NUM_BOARDS   = 9,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        init_done,
    output logic        proto_err
);

    localparam int unsigned DEPTH = NUM_BOARDS * 64;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned PW    = $clog2(MAX_PENDING + 1);

    typedef enum logic {CLEAR, SERVE} state_t;

    state_t            state, state_next;
    logic [IW-1:0]     clr_idx, clr_idx_next;
    logic [7:0]        mem [DEPTH];
    logic [PW-1:0]     pending, pending_next;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [7:0]        pipe_d [READ_LATENCY];

    logic [29:0]       word_idx;
    logic              in_range;
    logic [7:0]        rd_word;
    logic [7:0]        clr_word;
    logic              rd_acc, wr_acc;
    logic              mem_we;
    logic [IW-1:0]     mem_waddr;
    logic [7:0]        mem_wdata;
    logic              wait_next, err_next, init_next;
    logic              unused_wdata_hi;

    assign unused_wdata_hi = ^slave_writedata[31:8];

`ifdef BOARD_STORE_START_POS_EN
    function automatic logic [7:0] start_word(input logic [IW-1:0] idx);
        logic [7:0] back;
        logic [7:0] w;
        case (idx[2:0])
            3'd0, 3'd7: back = 8'd4;
            3'd1, 3'd6: back = 8'd2;
            3'd2, 3'd5: back = 8'd3;
            3'd3:       back = 8'd5;
            default:    back = 8'd6;
        endcase
        w = 8'd0;
        if (32'(idx) < 32'd64) begin
            case (idx[5:3])
                3'd0:    w = back;
                3'd1:    w = 8'd1;
                3'd6:    w = 8'hFF;
                3'd7:    w = 8'd0 - back;
                default: w = 8'd0;
            endcase
        end
        return w;
    endfunction
    assign clr_word = start_word(clr_idx);
`else
    assign clr_word = 8'd0;
`endif

    // Address decode; out-of-range reads return 0xFF, which sign-extends to all ones.
    always_comb begin
        word_idx = 30'((slave_address - BASE_ADDR) >> 2);
        in_range = (slave_address >= BASE_ADDR) && (word_idx < 30'(DEPTH));
        rd_word  = in_range ? mem[word_idx[IW-1:0]] : 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        mem_we       = 1'b0;
        mem_waddr    = clr_idx;
        mem_wdata    = 8'd0;
        rd_acc       = 1'b0;
        wr_acc       = 1'b0;
        err_next     = proto_err;
        init_next    = init_done;
        pending_next = pending;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = clr_word;
                init_next = 1'b0;
                if (clr_idx == IW'(DEPTH - 1)) begin
                    state_next   = SERVE;
                    clr_idx_next = '0;
                    init_next    = 1'b1;
                end else begin
                    clr_idx_next = clr_idx + IW'(1);
                end
            end
            SERVE: begin
                wr_acc = slave_write && !slave_waitrequest;
                rd_acc = slave_read && !slave_write && !slave_waitrequest;
                if (wr_acc && in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = word_idx[IW-1:0];
                    mem_wdata = slave_writedata[7:0];
                end
                if ((wr_acc || rd_acc) && !in_range) err_next = 1'b1;
                if (wr_acc && slave_read)            err_next = 1'b1;
            end
            default: state_next = CLEAR;
        endcase
        // A read retires on the cycle its valid is presented
        case ({rd_acc, slave_readdatavalid})
            2'b10:   pending_next = pending + PW'(1);
            2'b01:   pending_next = pending - PW'(1);
            default: pending_next = pending;
        endcase
        wait_next = (state_next == CLEAR) ||
                    ((pending_next == PW'(MAX_PENDING)) && !pipe_v[READ_LATENCY-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending             <= '0;
            pipe_v              <= '0;
            slave_waitrequest   <= 1'b1;
            slave_readdatavalid <= 1'b0;
            slave_readdata      <= 32'h0;
            init_done           <= 1'b0;
            proto_err           <= 1'b0;
        end else begin
            pending             <= pending_next;
            pipe_v[0]           <= rd_acc;
            for (int i = 1; i < int'(READ_LATENCY); i++) pipe_v[i] <= pipe_v[i-1];
            slave_waitrequest   <= wait_next;
            slave_readdatavalid <= pipe_v[READ_LATENCY-1];
            if (pipe_v[READ_LATENCY-1])
                slave_readdata <= {{24{pipe_d[READ_LATENCY-1][7]}}, pipe_d[READ_LATENCY-1]};
            init_done           <= init_next;
            proto_err           <= err_next;
        end
    end

    // RAM and read-data pipe carry no reset; the valid pipe gates them.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        pipe_d[0] <= rd_word;
        for (int i = 1; i < int'(READ_LATENCY); i++) pipe_d[i] <= pipe_d[i-1];
    end

endmodule

// File: tb/tb_board_store.sv
// Directed bench for board_store: instance 0 uses default parameters, instance 1 uses READ_LATENCY=8.
module tb_board_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_rd  [2];
    logic        bus_wr  [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic        waitreq [2];
    logic        valid   [2];
    logic        done    [2];
    logic        perr    [2];
    logic [31:0] rdata   [2];

    int vectors = 0;
    int errors  = 0;

`ifdef BOARD_STORE_START_POS_EN
    localparam logic [31:0] EXP_W1  = 32'h0000_0002;
    localparam logic [31:0] EXP_W57 = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] EXP_W1  = 32'h0000_0000;
    localparam logic [31:0] EXP_W57 = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    board_store u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(waitreq[0]), .slave_address(addr[0]), .slave_read(bus_rd[0]),
        .slave_readdata(rdata[0]), .slave_readdatavalid(valid[0]), .slave_write(bus_wr[0]),
        .slave_writedata(wdata[0]), .init_done(done[0]), .proto_err(perr[0])
    );

    board_store #(.READ_LATENCY(8), .MAX_PENDING(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(waitreq[1]), .slave_address(addr[1]), .slave_read(bus_rd[1]),
        .slave_readdata(rdata[1]), .slave_readdatavalid(valid[1]), .slave_write(bus_wr[1]),
        .slave_writedata(wdata[1]), .init_done(done[1]), .proto_err(perr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int s, input logic [31:0] a, input logic [31:0] d);
        int g;
        @(negedge clk);
        addr[s] = a; wdata[s] = d; bus_wr[s] = 1'b1;
        g = 0;
        while (waitreq[s] && g < 1000) begin @(negedge clk); g++; end
        check("wr_accept", 32'(g < 1000), 32'd1);
        @(posedge clk); #1;
        bus_wr[s] = 1'b0;
    endtask

    task automatic bus_read(input int s, input logic [31:0] a, output logic [31:0] d, output int lat);
        int g;
        @(negedge clk);
        addr[s] = a; bus_rd[s] = 1'b1;
        g = 0;
        while (waitreq[s] && g < 1000) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        bus_rd[s] = 1'b0;
        d = 32'hDEAD_BEEF; lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid[s]) begin d = rdata[s]; lat = i; break; end
        end
    endtask

    task automatic wait_init(output int cyc, output int bad_wait, output int nvalid);
        cyc = 0; bad_wait = 0; nvalid = 0;
        while (!done[0] && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            if (!done[0] && !(waitreq[0] && waitreq[1])) bad_wait++;
            if (valid[0] || valid[1]) nvalid++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] got [6];
        int lat, cyc, bad, nv, first_wait, extra;

        for (int s = 0; s < 2; s++) begin
            bus_rd[s] = 1'b0; bus_wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_waitreq", 32'(waitreq[0]), 32'd1);
        check("rst_valid",   32'(valid[0]),   32'd0);
        check("rst_rdata",   rdata[0],        32'h0);
        check("rst_init",    32'(done[0]),    32'd0);
        check("rst_perr",    32'(perr[0]),    32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clear sweep length and waitrequest throughout
        wait_init(cyc, bad, nv);
        check("clear_cycles",  32'(cyc),        32'd576);
        check("clear_wait",    32'(bad),        32'd0);
        check("clear_valid",   32'(nv),         32'd0);
        check("init1",         32'(done[1]),    32'd1);
        check("serve_waitreq", 32'(waitreq[0]), 32'd0);

        bus_read(0, 32'h4, d, lat);
        check("rd_w1",     d,          EXP_W1);
        check("rd_w1_lat", 32'(lat),   32'd2);

        bus_write(0, 32'(4 * 57), 32'hFFFF_FFFE);
        bus_read(0, 32'(4 * 57), d, lat);
        check("raw_w57",     d,        32'hFFFF_FFFE);
        check("raw_w57_lat", 32'(lat), 32'd2);

        bus_write(0, 32'h0000_000B, 32'h1234_5683);
        bus_read(0, 32'h8, d, lat);
        check("sext_w2", d,             32'hFFFF_FF83);
        check("perr0_0", 32'(perr[0]),  32'd0);

        // Backpressure and ordering with 8-cycle latency
        for (int k = 0; k < 6; k++) bus_write(1, 32'(4 * k), 32'(10 + k));
        first_wait = -1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    int g;
                    @(negedge clk);
                    addr[1] = 32'(4 * k); bus_rd[1] = 1'b1;
                    g = 0;
                    while (waitreq[1] && g < 200) begin
                        if (first_wait < 0) first_wait = k;
                        @(negedge clk); g++;
                    end
                    @(posedge clk);
                end
                #1 bus_rd[1] = 1'b0;
            end
            begin
                int budget;
                budget = 0;
                for (int j = 0; j < 6; j++) begin
                    got[j] = 32'hDEAD_BEEF;
                    while (budget < 100) begin
                        @(posedge clk); #1; budget++;
                        if (valid[1]) begin got[j] = rdata[1]; break; end
                    end
                end
            end
        join
        check("bp_first_wait", 32'(first_wait), 32'd4);
        for (int j = 0; j < 6; j++) check($sformatf("bp_data%0d", j), got[j], 32'(10 + j));
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (valid[1]) extra++; end
        check("bp_extra_valid", 32'(extra), 32'd0);

        // Out-of-range read, then an in-range write
        bus_read(0, 32'(4 * 576), d, lat);
        check("oor_data", d,            32'hFFFF_FFFF);
        check("oor_lat",  32'(lat),     32'd2);
        check("oor_perr", 32'(perr[0]), 32'd1);
        bus_write(0, 32'h0, 32'd5);
        bus_read(0, 32'h0, d, lat);
        check("after_oor_w0", d,            32'd5);
        check("perr_sticky",  32'(perr[0]), 32'd1);

        // Simultaneous read and write
        check("perr1_0", 32'(perr[1]), 32'd0);
        @(negedge clk);
        addr[1] = 32'h100; wdata[1] = 32'd3; bus_rd[1] = 1'b1; bus_wr[1] = 1'b1;
        @(posedge clk); #1;
        bus_rd[1] = 1'b0; bus_wr[1] = 1'b0;
        extra = 0;
        repeat (12) begin @(posedge clk); #1; if (valid[1]) extra++; end
        check("both_no_valid", 32'(extra),   32'd0);
        check("both_perr",     32'(perr[1]), 32'd1);
        bus_read(1, 32'h100, d, lat);
        check("both_wr_data", d,        32'd3);
        check("both_rd_lat",  32'(lat), 32'd8);

        // Reset with three reads in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            addr[1] = 32'(4 * k); bus_rd[1] = 1'b1;
            @(posedge clk);
        end
        #1 bus_rd[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_init0", 32'(done[0]),    32'd0);
        check("mid_rst_init1", 32'(done[1]),    32'd0);
        check("mid_rst_wait",  32'(waitreq[1]), 32'd1);
        check("mid_rst_perr",  32'(perr[1]),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc, bad, nv);
        check("reclear_cycles", 32'(cyc), 32'd576);
        check("reclear_wait",   32'(bad), 32'd0);
        check("reclear_valid",  32'(nv),  32'd0);
        bus_read(0, 32'(4 * 57), d, lat);
        check("reclear_w57", d, EXP_W57);
        bus_read(1, 32'h100, d, lat);
        check("reclear_w64", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
